kernel_weight_fetcher: RTL



---
 rtl/kernel_weight_fetcher_if.sv | 60 ++++++
 rtl/kernel_weight_fetcher.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/kernel_weight_fetcher_if.sv
// ----------------------------------------------------------------------------
// kernel_weight_fetcher_if
//
// Purpose: bundles the three buses of the kernel weight fetcher. These are the
// fetch request channel, the read-only kernel BRAM port, and the weight beat
// stream toward the convolution accumulate stage.
//
// Modports:
//   master - the fetcher's view. It accepts requests, drives the BRAM port and
//            sources weight beats.
//   slave  - the environment's view. It issues requests, models the BRAM and
//            consumes weight beats.
//
// Signals:
//   req_valid/req_ready/req_channel : fetch request handshake
//   err                             : one-cycle pulse on a dropped bad request
//   bram_en/we/addr/din/dout        : kernel BRAM port (read-only use)
//   w_valid/w_ready/w_data/w_pos/w_last : weight beat stream
//   busy                            : fetcher not idle
// ----------------------------------------------------------------------------
interface kernel_weight_fetcher_if #(
    parameter int KERNEL_WEIGHT_BITS = 6,
    parameter int KERNEL_SIZE        = 3,
    parameter int IN_CHANNELS        = 6,
    parameter int OUT_CHANNELS       = 6,
    parameter int DATA_WIDTH         = KERNEL_WEIGHT_BITS * OUT_CHANNELS,
    parameter int ADDR_WIDTH         = $clog2(IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE)
);
    localparam int P     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CH_W  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int POS_W = (P > 1) ? $clog2(P) : 1;

    logic                  req_valid;
    logic                  req_ready;
    logic [CH_W-1:0]       req_channel;
    logic                  err;
    logic                  bram_en;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [DATA_WIDTH-1:0] bram_dout;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [POS_W-1:0]      w_pos;
    logic                  w_last;
    logic                  busy;

    modport master (
        input  req_valid, req_channel, bram_dout, w_ready,
        output req_ready, err, bram_en, bram_we, bram_addr, bram_din,
               w_valid, w_data, w_pos, w_last, busy
    );

    modport slave (
        output req_valid, req_channel, bram_dout, w_ready,
        input  req_ready, err, bram_en, bram_we, bram_addr, bram_din,
               w_valid, w_data, w_pos, w_last, busy
    );
endinterface

// File: rtl/kernel_weight_fetcher.sv
// ----------------------------------------------------------------------------
// kernel_weight_fetcher
//
// Purpose: reads the KxK kernel window of one input channel out of the kernel
// weight BRAM. It streams the window one kernel position per beat, in
// row-major order. The BRAM's one-cycle read latency is absorbed by a 2-entry
// output FIFO, so the consumer may stall at any time without data loss.
//
// Ports:
//   clk  - clock, all logic on the rising edge
//   rst  - synchronous active-high reset
//   bus  - kernel_weight_fetcher_if.master carrying the request handshake, the
//          BRAM port (address = channel*K*K + pos) and the weight beat stream
// ----------------------------------------------------------------------------
module kernel_weight_fetcher #(
    parameter int KERNEL_WEIGHT_BITS = 6,
    parameter int KERNEL_SIZE        = 3,
    parameter int IN_CHANNELS        = 6,
    parameter int OUT_CHANNELS       = 6,
    parameter int DATA_WIDTH         = KERNEL_WEIGHT_BITS * OUT_CHANNELS,
    parameter int ADDR_WIDTH         = $clog2(IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst,
    kernel_weight_fetcher_if.master         bus
);
    localparam int P     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CH_W  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int POS_W = (P > 1) ? $clog2(P) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(P - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [POS_W-1:0]      issue_pos_q, issue_pos_d;
    logic                  pending_q, pending_d;
    logic [POS_W-1:0]      pending_pos_q, pending_pos_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [DATA_WIDTH-1:0] fifo_data_d [2];
    logic [POS_W-1:0]      fifo_pos_q [2];
    logic [POS_W-1:0]      fifo_pos_d [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  err_q, err_d;

    logic                  pop;
    logic                  issue;
    logic [POS_W-1:0]      head_pos;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        issue_pos_d   = issue_pos_q;
        fifo_data_d   = fifo_data_q;
        fifo_pos_d    = fifo_pos_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        err_d         = 1'b0;

        head_pos = fifo_pos_q[rd_ptr_q];
        pop      = (count_q != 2'd0) && bus.w_ready;

        // A read may only be issued if the FIFO has room for it once all reads
        // already in flight have landed. A pop in this cycle frees one slot, so
        // issue restarts in the very cycle the consumer becomes ready again.
        issue = (state_q == FETCH) &&
                (({1'b0, count_q} + {2'b0, pending_q}) < (3'd2 + {2'b0, pop}));

        // The read issued now returns next cycle. Its position tag travels with it.
        pending_d     = issue;
        pending_pos_d = issue_pos_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if ((CH_W + 1)'(bus.req_channel) < (CH_W + 1)'(IN_CHANNELS)) begin
                        base_d      = ADDR_WIDTH'(bus.req_channel) * ADDR_WIDTH'(P);
                        issue_pos_d = '0;
                        state_d     = FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (issue) begin
                    issue_pos_d = issue_pos_q + POS_W'(1);
                    if (issue_pos_q == POS_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last position is always issued before entering DRAIN, so its
                // beat can only leave the FIFO here.
                if (pop && (head_pos == POS_LAST)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pending_q) begin
            fifo_data_d[wr_ptr_q] = bus.bram_dout;
            fifo_pos_d[wr_ptr_q]  = pending_pos_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, pending_q} - {1'b0, pop};
    end

    // Reset drops the in-flight read too. Data the BRAM returns afterwards is
    // never written into the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            issue_pos_q   <= '0;
            pending_q     <= 1'b0;
            pending_pos_q <= '0;
            fifo_data_q   <= '{default: '0};
            fifo_pos_q    <= '{default: '0};
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            issue_pos_q   <= issue_pos_d;
            pending_q     <= pending_d;
            pending_pos_q <= pending_pos_d;
            fifo_data_q   <= fifo_data_d;
            fifo_pos_q    <= fifo_pos_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            err_q         <= err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;
    assign bus.bram_en   = issue;
    assign bus.bram_we   = 1'b0;
    assign bus.bram_din  = '0;
    assign bus.bram_addr = issue ? (base_q + ADDR_WIDTH'(issue_pos_q)) : '0;
    assign bus.w_valid   = (count_q != 2'd0);
    assign bus.w_data    = fifo_data_q[rd_ptr_q];
    assign bus.w_pos     = head_pos;
    assign bus.w_last    = (count_q != 2'd0) && (head_pos == POS_LAST);
endmodule
